// File: rtl/mem_port_arbiter_if.sv
// Bus between the IF/MEM stages, the memory-port arbiter and the external memory.
// The arbiter takes the slave view; the stages and memory together take the master view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    logic        ls_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, ls_rdata, ls_ack, ls_err, mem_addr, mem_wdata, mem_be, mem_re, mem_we
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, ls_rdata, ls_ack, ls_err, mem_addr, mem_wdata, mem_be, mem_re, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store: load/store wins,
// fetch is forced through after STARVE_LIMIT consecutive data grants while it waits.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int            SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, FAULT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [SW-1:0] r_streak;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;
    logic          r_mem_re;
    logic          r_mem_we;
    logic [1:0]    r_off;

    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_misalign;
    logic [1:0]    w_off;
    logic [3:0]    w_be;
    logic          w_done;
    logic          w_if_ack;
    logic          w_ls_ack;
    logic          w_ls_err;
    logic [31:0]   w_if_rdata;
    logic [31:0]   w_ls_rdata;

    assign w_off     = bus.ls_addr[1:0];
    assign w_grant_d = (r_state == IDLE) && bus.ls_req && !(bus.if_req && (r_streak == LIMIT));
    assign w_grant_i = (r_state == IDLE) && bus.if_req && !w_grant_d;
    assign w_done    = ((r_state == BUSY_I) || (r_state == BUSY_D)) && bus.mem_ready;

    // Byte lanes and alignment fault for the pending load/store; size 3 behaves as word.
    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        case (bus.ls_size)
            2'd0: w_be = 4'b0001 << w_off;
            2'd1: begin
                w_be       = 4'b0011 << w_off;
                w_misalign = w_off[0];
            end
            default: w_misalign = (w_off != 2'd0);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d)      w_next = w_misalign ? FAULT : BUSY_D;
                else if (w_grant_i) w_next = BUSY_I;
            end
            BUSY_I, BUSY_D: if (bus.mem_ready) w_next = IDLE;
            FAULT: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_if_ack   = (r_state == BUSY_I) && bus.mem_ready;
        w_ls_ack   = ((r_state == BUSY_D) && bus.mem_ready) || (r_state == FAULT);
        w_ls_err   = (r_state == FAULT);
        w_if_rdata = w_if_ack ? bus.mem_rdata : 32'h0;
        w_ls_rdata = 32'h0;
        if ((r_state == BUSY_D) && bus.mem_ready && !r_mem_we)
            w_ls_rdata = bus.mem_rdata >> {r_off, 3'b000};
    end

    // Memory command registers and the starvation streak; only written on a grant or completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_off       <= '0;
        end else if (w_grant_i) begin
            r_streak   <= '0;
            r_mem_addr <= bus.if_addr & ~32'h3;
            r_mem_be   <= 4'b1111;
            r_mem_re   <= 1'b1;
            r_mem_we   <= 1'b0;
        end else if (w_grant_d) begin
            if (!bus.if_req)            r_streak <= '0;
            else if (r_streak != LIMIT) r_streak <= r_streak + SW'(1);
            if (w_misalign) begin
                r_mem_be <= '0;
                r_mem_re <= 1'b0;
                r_mem_we <= 1'b0;
            end else begin
                r_mem_addr  <= bus.ls_addr & ~32'h3;
                r_mem_be    <= w_be;
                r_mem_wdata <= bus.ls_wdata << {w_off, 3'b000};
                r_mem_re    <= ~bus.ls_we;
                r_mem_we    <= bus.ls_we;
                r_off       <= w_off;
            end
        end else if (w_done) begin
            r_mem_be <= '0;
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
        end
    end

    assign bus.if_ack    = w_if_ack;
    assign bus.if_rdata  = w_if_rdata;
    assign bus.ls_ack    = w_ls_ack;
    assign bus.ls_err    = w_ls_err;
    assign bus.ls_rdata  = w_ls_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_re    = r_mem_re;
    assign bus.mem_we    = r_mem_we;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized requesters and memory.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [139:0] act, input logic [139:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic check_s(input string name, input string act, input string exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got \"%s\" expected \"%s\"", name, $time, act, exp);
    endtask

    // Reference model: the transaction currently owning the port and the registered command.
    typedef enum {K_NONE, K_I, K_D, K_F} kind_e;
    kind_e       m_kind;
    int          m_streak;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_re, m_we;
    int          m_off;
    string       g_log = "";

    task automatic m_reset();
        m_kind = K_NONE; m_streak = 0; m_addr = 0; m_wdata = 0;
        m_be = 0; m_re = 0; m_we = 0; m_off = 0;
    endtask

    // Predicts what happens at the coming rising edge from the inputs now on the bus.
    task automatic m_step();
        int nb, off;
        case (m_kind)
            K_NONE: begin
                if (bus.ls_req && !(bus.if_req && m_streak == LIMIT)) begin
                    nb  = (bus.ls_size == 2'd0) ? 1 : (bus.ls_size == 2'd1) ? 2 : 4;
                    off = int'(bus.ls_addr % 4);
                    m_streak = bus.if_req ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
                    if (off % nb != 0) begin
                        m_kind = K_F; g_log = {g_log, "F"};
                        m_be = 0; m_re = 0; m_we = 0;
                    end else begin
                        m_kind  = K_D; g_log = {g_log, "D"};
                        m_addr  = bus.ls_addr - 32'(off);
                        m_be    = 4'(((1 << nb) - 1) << off);
                        m_wdata = bus.ls_wdata << (8 * off);
                        m_re    = !bus.ls_we;
                        m_we    = bus.ls_we;
                        m_off   = off;
                    end
                end else if (bus.if_req) begin
                    m_kind = K_I; g_log = {g_log, "I"};
                    m_streak = 0;
                    m_addr = bus.if_addr - (bus.if_addr % 4);
                    m_be = 4'hF; m_re = 1; m_we = 0;
                end
            end
            K_I, K_D: if (bus.mem_ready) begin
                m_kind = K_NONE; m_be = 0; m_re = 0; m_we = 0;
            end
            default: m_kind = K_NONE;
        endcase
    endtask

    function automatic logic [139:0] dut_outs();
        return {3'b000, bus.if_ack, bus.if_rdata, bus.ls_ack, bus.ls_err, bus.ls_rdata,
                bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_re, bus.mem_we};
    endfunction

    always @(negedge clk) begin
        logic        e_iack, e_lack, e_lerr;
        logic [31:0] e_ird, e_lrd;
        if (!rst_n) m_reset();
        e_iack = (m_kind == K_I) && bus.mem_ready;
        e_lack = ((m_kind == K_D) && bus.mem_ready) || (m_kind == K_F);
        e_lerr = (m_kind == K_F);
        e_ird  = e_iack ? bus.mem_rdata : 32'h0;
        e_lrd  = ((m_kind == K_D) && bus.mem_ready && !m_we) ? (bus.mem_rdata >> (8 * m_off)) : 32'h0;
        check("cycle_outputs", dut_outs(),
              {3'b000, e_iack, e_ird, e_lack, e_lerr, e_lrd, m_addr, m_wdata, m_be, m_re, m_we});
        if (rst_n) m_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ia, la, found;
        m_reset();
        bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = 0;
        bus.ls_addr = 0; bus.ls_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;

        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs", dut_outs(), 140'h0);
        tick();
        rst_n = 1;

        // Fetch only, zero-wait
        bus.if_req = 1; bus.if_addr = 32'h0000_1006; bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE_BABE;
        tick();
        @(negedge clk);
        check("fetch_addr", bus.mem_addr, 32'h1004);
        check("fetch_be", bus.mem_be, 4'hF);
        check("fetch_re_we", {bus.mem_re, bus.mem_we}, 2'b10);
        check("fetch_ack", {bus.if_ack, bus.if_rdata}, {1'b1, 32'hCAFE_BABE});
        tick();
        bus.if_req = 0;

        // Store byte to lane 3
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_size = 0; bus.ls_addr = 32'h203; bus.ls_wdata = 32'hA5;
        tick();
        @(negedge clk);
        check("sb_addr", bus.mem_addr, 32'h200);
        check("sb_be", bus.mem_be, 4'b1000);
        check("sb_wdata", bus.mem_wdata, 32'hA500_0000);
        check("sb_re_we", {bus.mem_re, bus.mem_we}, 2'b01);
        check("sb_ack", {bus.ls_ack, bus.ls_err, bus.ls_rdata}, {2'b10, 32'h0});
        tick();

        // Load half from upper lanes with three wait cycles
        bus.ls_we = 0; bus.ls_size = 1; bus.ls_addr = 32'h102; bus.mem_ready = 0; bus.mem_rdata = 32'h8001_1234;
        for (int w = 0; w < 3; w++) begin
            tick();
            @(negedge clk);
            check("lh_wait_ack", bus.ls_ack, 1'b0);
            check("lh_wait_cmd", {bus.mem_addr, bus.mem_be, bus.mem_re}, {32'h100, 4'b1100, 1'b1});
        end
        tick();
        bus.mem_ready = 1;
        @(negedge clk);
        check("lh_ack", {bus.ls_ack, bus.ls_err}, 2'b10);
        check("lh_rdata16", bus.ls_rdata[15:0], 16'h8001);
        tick();

        // Misaligned word load faults without touching memory
        bus.ls_size = 2; bus.ls_addr = 32'h6; bus.mem_ready = 0;
        tick();
        @(negedge clk);
        check("lw_fault_ack", {bus.ls_ack, bus.ls_err, bus.ls_rdata}, {2'b11, 32'h0});
        check("lw_fault_cmd", {bus.mem_re, bus.mem_we, bus.mem_be}, 6'h0);
        tick();
        bus.ls_req = 0;
        @(negedge clk);
        check("lw_after_fault", {bus.mem_re, bus.mem_we, bus.ls_ack}, 3'b000);

        // Both requesters permanently active, zero-wait
        tick();
        g_log = "";
        bus.if_req = 1; bus.if_addr = 32'h40;
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_size = 2; bus.ls_addr = 32'h80; bus.ls_wdata = 32'h1234_5678;
        bus.mem_ready = 1;
        repeat (21) tick();
        check_s("grant_order", g_log.substr(0, 9), "DDDDIDDDDI");

        // Park in a store with the streak saturated, then reset mid-transaction
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (m_kind == K_D && m_streak == LIMIT) begin
                bus.mem_ready = 0;
                found = 1;
            end
        end
        check("streak_preload", found, 1'b1);
        tick();
        check("pre_reset_we", bus.mem_we, 1'b1);
        #2 rst_n = 0;
        #1;
        check("async_reset_cmd", {bus.mem_we, bus.mem_re, bus.mem_be}, 6'h0);
        @(negedge clk);
        tick();
        g_log = "";
        rst_n = 1;
        bus.mem_ready = 1;
        repeat (2) tick();
        check_s("post_reset_grant", g_log.substr(0, 0), "D");

        // Randomized requesters and memory
        bus.if_req = 0; bus.ls_req = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ia = bus.if_ack;
            la = bus.ls_ack;
            tick();
            if (bus.if_req ? ia : ($urandom_range(0, 3) == 0)) begin
                bus.if_req  = bus.if_req ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.if_addr = $urandom;
            end
            if (bus.ls_req ? la : ($urandom_range(0, 3) == 0)) begin
                bus.ls_req   = bus.ls_req ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.ls_we    = 1'($urandom_range(0, 1));
                bus.ls_size  = 2'($urandom_range(0, 3));
                bus.ls_addr  = $urandom;
                bus.ls_wdata = $urandom;
            end
            bus.mem_ready = ($urandom_range(0, 9) < 6);
            bus.mem_rdata = $urandom;
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
